hazard_unit: RTL and testbench

Parametrised pipeline hazard unit for the 5-stage core. It sits between the IF/ID and ID/EX registers and replaces the single-cycle load-use detector. It adds a configurable multi-cycle load-use stall, a multi-cycle mul/div busy interlock, register-0 and unused-operand filtering, and IF/ID flush on taken branches. It drives the PC write enable, the IF/ID write enable, the ID/EX control-bubble mux select and the IF/ID flush.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_unit_stall_counter.sv | 38 +++
 rtl/hazard_unit.sv | 116 +++++++++++
 tb/tb_hazard_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and widths for the pipeline hazard unit
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LD_STALL = 1'b1
    } hz_state_e;

    // Load stall length is at most 7 cycles; mul/div occupancy at most 255.
    localparam int LD_CNT_W = 3;
    localparam int MD_CNT_W = 8;

endpackage

// File: rtl/hazard_unit_stall_counter.sv
// rtl/hazard_unit_stall_counter.sv - loadable down-counter that stops at zero
module stall_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down until empty.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use / mul-div interlock and branch flush control
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MD_CYCLES    = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] if_id_rs_i,
    input  logic [REG_AW-1:0] if_id_rt_i,
    input  logic              if_id_rs_used_i,
    input  logic              if_id_rt_used_i,
    input  logic              if_id_md_use_i,
    input  logic [REG_AW-1:0] id_ex_rd_i,
    input  logic              id_ex_memread_i,
    input  logic              md_start_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              bubble_o,
    output logic              if_id_flush_o,
    output logic              md_busy_o
);

    hz_state_e state_q;
    hz_state_e state_d;

    logic [LD_CNT_W-1:0] ld_cnt;
    logic                ld_zero;
    logic                ld_load;
    logic [MD_CNT_W-1:0] md_cnt;
    logic                md_zero;
    logic                md_load;

    logic rs_match;
    logic rt_match;
    logic ld_hit;
    logic md_hit;
    logic stall;

    // Operand comparison, ignoring operands the instruction does not read.
    always_comb begin
        rs_match = if_id_rs_used_i && (if_id_rs_i == id_ex_rd_i);
        rt_match = if_id_rt_used_i && (if_id_rt_i == id_ex_rd_i);
    end

    // Hazard detection and output decode; r0 never creates a dependency.
    always_comb begin
        ld_hit        = (state_q == RUN) && id_ex_memread_i &&
                        (id_ex_rd_i != '0) && (rs_match || rt_match);
        md_busy_o     = (md_cnt != '0);
        md_hit        = if_id_md_use_i && md_busy_o;
        stall         = ld_hit || (state_q == LD_STALL) || md_hit;
        pc_write_o    = !stall;
        if_id_write_o = !stall;
        bubble_o      = stall;
        // A branch seen while stalled stays in ID and resolves again later.
        if_id_flush_o = branch_taken_i && !stall;
        // Single-bubble loads clear themselves once the bubble reaches EX.
        ld_load       = ld_hit && (LOAD_BUBBLES > 1);
        // A start while the unit is occupied is dropped.
        md_load       = md_start_i && md_zero;
    end

    // Load-stall FSM next state: hold LD_STALL until the last extra bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (ld_load) begin
                    state_d = LD_STALL;
                end
            end
            LD_STALL: begin
                if ((ld_cnt == LD_CNT_W'(1)) || ld_zero) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Load-stall FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    stall_counter #(
        .W (LD_CNT_W)
    ) u_ld_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (ld_load),
        .load_val_i (LD_CNT_W'(LOAD_BUBBLES - 1)),
        .cnt_o      (ld_cnt),
        .zero_o     (ld_zero)
    );

    stall_counter #(
        .W (MD_CNT_W)
    ) u_md_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (md_load),
        .load_val_i (MD_CNT_W'(MD_CYCLES)),
        .cnt_o      (md_cnt),
        .zero_o     (md_zero)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized and directed check of hazard_unit against a cycle model
module tb_hazard_unit;

    localparam int AW   = 5;
    localparam int LB0  = 1;
    localparam int LB1  = 3;
    localparam int MDC  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rs = '0, rt = '0, rd = '0;
    logic          rs_used = 1'b0, rt_used = 1'b0, md_use = 1'b0;
    logic          memread = 1'b0, md_start = 1'b0, branch = 1'b0;

    logic pc_w [2];
    logic ifid_w [2];
    logic bub [2];
    logic flush [2];
    logic busy [2];

    int n_tests = 0;
    int n_fail  = 0;
    int ld_rem [2];
    int md_rem [2];
    int bub_cnt [2];
    int busy_cnt [2];

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(AW), .LOAD_BUBBLES(LB0), .MD_CYCLES(MDC)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_id_rs_i(rs), .if_id_rt_i(rt),
        .if_id_rs_used_i(rs_used), .if_id_rt_used_i(rt_used),
        .if_id_md_use_i(md_use), .id_ex_rd_i(rd), .id_ex_memread_i(memread),
        .md_start_i(md_start), .branch_taken_i(branch),
        .pc_write_o(pc_w[0]), .if_id_write_o(ifid_w[0]), .bubble_o(bub[0]),
        .if_id_flush_o(flush[0]), .md_busy_o(busy[0])
    );

    hazard_unit #(.REG_AW(AW), .LOAD_BUBBLES(LB1), .MD_CYCLES(MDC)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_id_rs_i(rs), .if_id_rt_i(rt),
        .if_id_rs_used_i(rs_used), .if_id_rt_used_i(rt_used),
        .if_id_md_use_i(md_use), .id_ex_rd_i(rd), .id_ex_memread_i(memread),
        .md_start_i(md_start), .branch_taken_i(branch),
        .pc_write_o(pc_w[1]), .if_id_write_o(ifid_w[1]), .bubble_o(bub[1]),
        .if_id_flush_o(flush[1]), .md_busy_o(busy[1])
    );

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", tag, k, obs, exp, $time);
        end
    endtask

    task automatic set_in(input logic [AW-1:0] a_rs, input logic a_rs_used,
                          input logic [AW-1:0] a_rt, input logic a_rt_used,
                          input logic [AW-1:0] a_rd, input logic a_memread,
                          input logic a_md_use, input logic a_md_start, input logic a_branch);
        rs = a_rs; rs_used = a_rs_used; rt = a_rt; rt_used = a_rt_used;
        rd = a_rd; memread = a_memread; md_use = a_md_use;
        md_start = a_md_start; branch = a_branch;
    endtask

    task automatic idle();
        set_in('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_pc"}, k, 32'(pc_w[k]), 32'd1);
            check({tag, "_ifid"}, k, 32'(ifid_w[k]), 32'd1);
            check({tag, "_bub"}, k, 32'(bub[k]), 32'd0);
            check({tag, "_flush"}, k, 32'(flush[k]), 32'd0);
            check({tag, "_busy"}, k, 32'(busy[k]), 32'd0);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ld_rem[k] = 0;
            md_rem[k] = 0;
        end
    endtask

    // One pipeline cycle: compare outputs mid-cycle, then advance the model
    // with the same inputs the DUT sees at the coming rising edge.
    task automatic cycle();
        bit hit, bsy, st;
        int lb;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            lb  = (k == 0) ? LB0 : LB1;
            hit = (ld_rem[k] == 0) && memread && (rd != 0) &&
                  ((rs_used && rs == rd) || (rt_used && rt == rd));
            bsy = (md_rem[k] > 0);
            st  = hit || (ld_rem[k] > 0) || (md_use && bsy);
            check("pc_write", k, 32'(pc_w[k]), 32'(!st));
            check("if_id_write", k, 32'(ifid_w[k]), 32'(!st));
            check("bubble", k, 32'(bub[k]), 32'(st));
            check("flush", k, 32'(flush[k]), 32'(branch && !st));
            check("md_busy", k, 32'(busy[k]), 32'(bsy));
            if (bub[k]) bub_cnt[k]++;
            if (busy[k]) busy_cnt[k]++;
            if (ld_rem[k] > 0) ld_rem[k]--;
            else if (hit) ld_rem[k] = lb - 1;
            if (md_rem[k] == 0 && md_start) md_rem[k] = MDC;
            else if (md_rem[k] > 0) md_rem[k]--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            bub_cnt[k] = 0;
            busy_cnt[k] = 0;
        end
    endtask

    initial begin
        model_reset();
        clear_counts();
        idle();
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load r3 in EX, ID reads rs=3 for one cycle, then the bubble clears EX.
        clear_counts();
        set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        idle();
        repeat (4) cycle();
        check("ld_bubbles", 0, 32'(bub_cnt[0]), 32'(LB0));
        check("ld_bubbles", 1, 32'(bub_cnt[1]), 32'(LB1));

        // Destination r0 and unused operand never stall.
        clear_counts();
        set_in(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        set_in(5'd3, 1'b0, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        idle();
        cycle();
        check("no_stall_bubbles", 0, 32'(bub_cnt[0]), 32'd0);
        check("no_stall_bubbles", 1, 32'(bub_cnt[1]), 32'd0);

        // Mul/div pulse, then mflo waiting in ID.
        clear_counts();
        set_in('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        set_in('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) cycle();
        check("md_busy_cycles", 0, 32'(busy_cnt[0]), 32'(MDC));
        check("md_stall_cycles", 1, 32'(bub_cnt[1]), 32'(MDC));

        // Non-md instruction during busy is not stalled.
        clear_counts();
        set_in('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        idle();
        repeat (5) cycle();
        check("md_nonuse_bubbles", 0, 32'(bub_cnt[0]), 32'd0);
        check("md_nonuse_busy", 1, 32'(busy_cnt[1]), 32'(MDC));

        // Branch alone flushes; branch with a load-use hit is held.
        set_in('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        set_in(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        idle();
        repeat (3) cycle();

        // Reset asserted in the second cycle of the 3-cycle load stall.
        set_in(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        idle();
        @(negedge clk);
        #1;
        check("stall_2nd_cycle", 1, 32'(bub[1]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_counts();
        repeat (3) cycle();
        check("post_reset_bubbles", 1, 32'(bub_cnt[1]), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_in(AW'($urandom_range(0, 3)), 1'($urandom),
                   AW'($urandom_range(0, 3)), 1'($urandom),
                   AW'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
